// File: rtl/rv_enc_pkg.sv
// rtl/rv_enc_pkg.sv - shared types and RV32I opcode constants for the instruction encoder/loader
package rv_enc_pkg;

  typedef enum logic [1:0] {
    UOP_R = 2'd0,
    UOP_I = 2'd1,
    UOP_S = 2'd2,
    UOP_B = 2'd3
  } uop_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

endpackage

// File: rtl/inst_field_pack.sv
// rtl/inst_field_pack.sv - combinational packer from micro-op fields to an RV32I instruction word
module inst_field_pack
  import rv_enc_pkg::*;
(
  input  uop_type_e   uop_type_i,
  input  logic [3:0]  alu_sel_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [12:0] imm_i,
  output logic [31:0] word_o,
  output logic        misalign_o
);

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm_i12;

  assign f3 = alu_sel_i[2:0];
  assign f7 = {1'b0, alu_sel_i[3], 5'b00000};

  // Shift-immediates carry funct7 in the upper immediate bits instead of sign extension.
  assign imm_i12 = ((f3 == F3_SLL) || (f3 == F3_SR)) ? {f7, imm_i[4:0]} : imm_i[11:0];

  always_comb begin
    word_o     = 32'h0;
    misalign_o = 1'b0;
    unique case (uop_type_i)
      UOP_R: word_o = {f7, rs2_i, rs1_i, f3, rd_i, OPC_OP};
      UOP_I: word_o = {imm_i12, rs1_i, f3, rd_i, OPC_OPIMM};
      UOP_S: word_o = {imm_i[11:5], rs2_i, rs1_i, F3_SW, imm_i[4:0], OPC_STORE};
      UOP_B: begin
        word_o     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3, imm_i[4:1], imm_i[11], OPC_BRANCH};
        misalign_o = imm_i[0];
      end
      default: word_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/inst_encode_loader.sv
// rtl/inst_encode_loader.sv - streams encoded micro-ops into IMEM through a one-entry write register
module inst_encode_loader
  import rv_enc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              uop_valid_i,
  output logic              uop_ready_o,
  input  logic [1:0]        uop_type_i,
  input  logic [3:0]        alu_sel_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [12:0]       imm_i,
  output logic              imem_we_o,
  input  logic              imem_ready_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  enc_state_e        state_q;
  logic [CNT_W-1:0]  acc_rem_q;
  logic [CNT_W-1:0]  wr_rem_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              err_q;

  logic [31:0]       packed_word;
  logic              packed_misalign;
  logic              uop_fire;
  logic              wr_fire;

  inst_field_pack u_pack (
    .uop_type_i (uop_type_e'(uop_type_i)),
    .alu_sel_i  (alu_sel_i),
    .rd_i       (rd_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .imm_i      (imm_i),
    .word_o     (packed_word),
    .misalign_o (packed_misalign)
  );

  // The output register may take a new word in the same cycle its current word drains.
  assign uop_ready_o = (state_q == ST_RUN) && (acc_rem_q != '0) && (!we_q || imem_ready_i);
  assign uop_fire    = uop_valid_i && uop_ready_o;
  assign wr_fire     = we_q && imem_ready_i;
  assign addr_d      = addr_q + ADDR_W'(4);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      acc_rem_q <= '0;
      wr_rem_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            addr_q    <= {base_addr_i[ADDR_W-1:2], 2'b00};
            acc_rem_q <= count_i;
            wr_rem_q  <= count_i;
            err_q     <= 1'b0;
            state_q   <= (count_i == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (uop_fire) begin
            wdata_q   <= packed_word;
            we_q      <= 1'b1;
            acc_rem_q <= acc_rem_q - CNT_W'(1);
            if (packed_misalign) err_q <= 1'b1;
          end else if (wr_fire) begin
            we_q <= 1'b0;
          end
          if (wr_fire) begin
            addr_q   <= addr_d;
            wr_rem_q <= wr_rem_q - CNT_W'(1);
            if (wr_rem_q == CNT_W'(1)) state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign busy_o       = (state_q == ST_RUN);
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = err_q;

endmodule
